// File: rtl/onewire_pkg.sv
// rtl/onewire_pkg.sv - shared 1-Wire constants and CRC-8 checker state type
package onewire_pkg;

    localparam logic [7:0] CRC8_POLY     = 8'h31;
    localparam logic [7:0] CRC8_INIT     = 8'h00;
    localparam int         ROM_DATA_BITS = 56;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2,
        DONE = 2'd3
    } crc8_state_t;

endpackage

// File: rtl/crc8_checker_if.sv
// rtl/crc8_checker_if.sv - control, bit-stream and result bundle of the CRC-8 checker
interface crc8_checker_if
    import onewire_pkg::*;
#(
    parameter int DATA_BITS = ROM_DATA_BITS
);
    logic                 i_start;
    logic                 i_abort;
    logic                 i_bit;
    logic                 i_bit_valid;
    logic                 o_busy;
    logic [DATA_BITS-1:0] o_data;
    logic [7:0]           o_crc_rx;
    logic [7:0]           o_crc_calc;
    logic                 o_crc_ok;
    logic                 o_done;

    modport master (
        output i_start, i_abort, i_bit, i_bit_valid,
        input  o_busy, o_data, o_crc_rx, o_crc_calc, o_crc_ok, o_done
    );

    modport slave (
        input  i_start, i_abort, i_bit, i_bit_valid,
        output o_busy, o_data, o_crc_rx, o_crc_calc, o_crc_ok, o_done
    );
endinterface

// File: rtl/crc8_step.sv
// rtl/crc8_step.sv - combinational one-bit MSB-first CRC-8 LFSR update
module crc8_step
    import onewire_pkg::*;
#(
    parameter logic [7:0] POLY = CRC8_POLY
) (
    input  logic [7:0] i_crc,
    input  logic       i_bit,
    output logic [7:0] o_crc
);
    logic w_fb;

    assign w_fb  = i_crc[7] ^ i_bit;
    assign o_crc = {i_crc[6:0], 1'b0} ^ (w_fb ? POLY : 8'h00);
endmodule

// File: rtl/crc8_checker.sv
// rtl/crc8_checker.sv - bit-serial receive-side CRC-8 checker for the 1-Wire master
module crc8_checker
    import onewire_pkg::*;
#(
    parameter int         DATA_BITS = ROM_DATA_BITS,
    parameter logic [7:0] CRC_POLY  = CRC8_POLY,
    parameter logic [7:0] CRC_INIT  = CRC8_INIT
) (
    input  logic            clk,
    input  logic            reset,
    crc8_checker_if.slave   bus
);
    localparam int CW = $clog2(DATA_BITS + 1);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_DATA = DATA;
    localparam logic [1:0] ST_CRC  = CRC;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]           r_state;
    logic [CW-1:0]        r_cnt;
    logic [7:0]           r_crc;
    logic [DATA_BITS-1:0] r_data;
    logic [7:0]           r_crc_rx;
    logic [7:0]           r_crc_calc;
    logic                 r_crc_ok;

    logic [7:0]           w_crc_next;
    logic [7:0]           w_crc_rx_next;
    logic                 w_last_data;
    logic                 w_last_crc;

    crc8_step #(.POLY(CRC_POLY)) u_step (
        .i_crc (r_crc),
        .i_bit (bus.i_bit),
        .o_crc (w_crc_next)
    );

    assign w_crc_rx_next = {r_crc_rx[6:0], bus.i_bit};
    assign w_last_data   = (r_cnt == CW'(DATA_BITS - 1));
    assign w_last_crc    = (r_cnt == CW'(7));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_crc      <= CRC_INIT;
            r_data     <= '0;
            r_crc_rx   <= '0;
            r_crc_calc <= '0;
            r_crc_ok   <= 1'b0;
        end else if (bus.i_start) begin
            // Restart wins over abort and any strobe in the same cycle
            r_state    <= ST_DATA;
            r_cnt      <= '0;
            r_crc      <= CRC_INIT;
            r_data     <= '0;
            r_crc_rx   <= '0;
            r_crc_calc <= '0;
            r_crc_ok   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                end
                ST_DATA: begin
                    if (bus.i_abort) begin
                        r_state  <= ST_IDLE;
                        r_crc_ok <= 1'b0;
                    end else if (bus.i_bit_valid) begin
                        r_crc  <= w_crc_next;
                        r_data <= {r_data[DATA_BITS-2:0], bus.i_bit};
                        if (w_last_data) begin
                            r_crc_calc <= w_crc_next;
                            r_cnt      <= '0;
                            r_state    <= ST_CRC;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_CRC: begin
                    if (bus.i_abort) begin
                        r_state  <= ST_IDLE;
                        r_crc_ok <= 1'b0;
                    end else if (bus.i_bit_valid) begin
                        r_crc    <= w_crc_next;
                        r_crc_rx <= w_crc_rx_next;
                        if (w_last_crc) begin
                            // Compare against the completed byte so the flag lands with o_done
                            r_crc_ok <= (r_crc_calc == w_crc_rx_next);
                            r_cnt    <= '0;
                            r_state  <= ST_DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    if (bus.i_abort) begin
                        r_crc_ok <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_busy     = (r_state == ST_DATA) || (r_state == ST_CRC);
    assign bus.o_done     = (r_state == ST_DONE);
    assign bus.o_data     = r_data;
    assign bus.o_crc_rx   = r_crc_rx;
    assign bus.o_crc_calc = r_crc_calc;
    assign bus.o_crc_ok   = r_crc_ok;
endmodule

// File: tb/tb_crc8_checker.sv
// tb/tb_crc8_checker.sv - randomized self-checking bench for crc8_checker
module tb_crc8_checker;
    import onewire_pkg::*;

    localparam int DB = 56;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   busy_cnt = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    crc8_checker_if #(.DATA_BITS(DB)) bus ();

    crc8_checker #(.DATA_BITS(DB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference CRC: remainder of payload * x^8 divided by the 9-bit generator polynomial
    function automatic logic [7:0] crc_model(input logic [DB-1:0] d);
        logic [DB+7:0] r;
        logic [8:0]    g;
        r = {d, 8'h00};
        g = {1'b1, CRC8_POLY};
        for (int i = DB + 7; i >= 8; i--) begin
            if (r[i]) r[i -: 9] = r[i -: 9] ^ g;
        end
        return r[7:0];
    endfunction

    function automatic logic frame_bit(input logic [DB-1:0] d, input logic [7:0] c, input int i);
        if (i < DB) return d[DB-1-i];
        return c[7-(i-DB)];
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (bus.o_busy) busy_cnt++;
        if (bus.o_done) done_cnt++;
    endtask

    task automatic start_pulse();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int gap);
        bus.i_bit_valid = 1'b0;
        repeat (gap) tick();
        bus.i_bit       = b;
        bus.i_bit_valid = 1'b1;
        tick();
        bus.i_bit_valid = 1'b0;
    endtask

    // Sends bits [first, last) of the frame; returns the total gap cycles inserted
    task automatic send_range(input logic [DB-1:0] d, input logic [7:0] c,
                              input int first, input int last, input int max_gap,
                              output int gaps);
        int g;
        gaps = 0;
        for (int i = first; i < last; i++) begin
            g = (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
            gaps += g;
            send_bit(frame_bit(d, c, i), g);
        end
    endtask

    task automatic check_done(input string tag, input logic [DB-1:0] d, input logic [7:0] c);
        logic [7:0] exp_calc;
        exp_calc = crc_model(d);
        check({tag, "_done"},  64'(bus.o_done), 64'(1));
        check({tag, "_data"},  64'(bus.o_data), 64'(d));
        check({tag, "_rx"},    64'(bus.o_crc_rx), 64'(c));
        check({tag, "_calc"},  64'(bus.o_crc_calc), 64'(exp_calc));
        check({tag, "_ok"},    64'(bus.o_crc_ok), 64'(exp_calc == c));
        tick();
        check({tag, "_pulse"}, 64'(done_cnt), 64'(1));
        check({tag, "_idle"},  64'(bus.o_busy), 64'(0));
        check({tag, "_hold"},  64'(bus.o_crc_ok), 64'(exp_calc == c));
    endtask

    task automatic run_frame(input string tag, input logic [DB-1:0] d, input logic [7:0] c,
                             input int max_gap);
        int gaps;
        busy_cnt = 0;
        done_cnt = 0;
        start_pulse();
        send_range(d, c, 0, DB + 8, max_gap, gaps);
        check({tag, "_busy"}, 64'(busy_cnt), 64'(DB + 8 + gaps));
        check_done(tag, d, c);
    endtask

    initial begin
        logic [DB-1:0] d;
        logic [7:0]    c;
        int            gaps;

        reset           = 1'b1;
        bus.i_start     = 1'b0;
        bus.i_abort     = 1'b0;
        bus.i_bit       = 1'b0;
        bus.i_bit_valid = 1'b0;
        repeat (3) tick();
        check("rst_busy", 64'(bus.o_busy), 64'(0));
        check("rst_done", 64'(bus.o_done), 64'(0));
        check("rst_data", 64'(bus.o_data), 64'(0));
        check("rst_rx",   64'(bus.o_crc_rx), 64'(0));
        check("rst_calc", 64'(bus.o_crc_calc), 64'(0));
        check("rst_ok",   64'(bus.o_crc_ok), 64'(0));
        reset = 1'b0;
        tick();

        run_frame("zero", '0, 8'h00, 2);
        check("zero_calc_const", 64'(bus.o_crc_calc), 64'(8'h00));
        run_frame("one", DB'(1), 8'h31, 3);
        check("one_calc_const", 64'(bus.o_crc_calc), 64'(8'h31));
        run_frame("one_bad", DB'(1), 8'h30, 1);
        run_frame("two_b2b", DB'(2), 8'h62, 0);
        check("two_calc_const", 64'(bus.o_crc_calc), 64'(8'h62));

        // Abort part-way through the payload
        d = {$urandom, $urandom};
        busy_cnt = 0;
        done_cnt = 0;
        start_pulse();
        send_range(d, 8'h00, 0, 30, 1, gaps);
        bus.i_abort = 1'b1;
        tick();
        bus.i_abort = 1'b0;
        check("abort_busy", 64'(bus.o_busy), 64'(0));
        check("abort_ok",   64'(bus.o_crc_ok), 64'(0));
        check("abort_data", 64'(bus.o_data), 64'(d >> (DB - 30)));
        send_bit(1'b1, 0);
        tick();
        check("abort_nodone", 64'(done_cnt), 64'(0));
        check("abort_ignored", 64'(bus.o_data), 64'(d >> (DB - 30)));
        run_frame("post_abort", DB'(1), 8'h31, 0);

        // Restart mid-frame with a coincident strobe that must be dropped
        d = {$urandom, $urandom};
        c = crc_model(d);
        busy_cnt = 0;
        done_cnt = 0;
        start_pulse();
        send_range(d, c, 0, 20, 1, gaps);
        bus.i_start     = 1'b1;
        bus.i_bit       = 1'b1;
        bus.i_bit_valid = 1'b1;
        tick();
        bus.i_start     = 1'b0;
        bus.i_bit_valid = 1'b0;
        check("restart_data", 64'(bus.o_data), 64'(0));
        d = {$urandom, $urandom};
        c = crc_model(d);
        done_cnt = 0;
        send_range(d, c, 0, DB + 8, 1, gaps);
        check_done("restart", d, c);

        // Reset during the CRC phase
        d = {$urandom, $urandom};
        c = crc_model(d);
        start_pulse();
        send_range(d, c, 0, DB + 4, 1, gaps);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_busy", 64'(bus.o_busy), 64'(0));
        check("mrst_done", 64'(bus.o_done), 64'(0));
        check("mrst_data", 64'(bus.o_data), 64'(0));
        check("mrst_rx",   64'(bus.o_crc_rx), 64'(0));
        check("mrst_calc", 64'(bus.o_crc_calc), 64'(0));
        check("mrst_ok",   64'(bus.o_crc_ok), 64'(0));
        busy_cnt = 0;
        done_cnt = 0;
        send_range(d, c, 0, 10, 0, gaps);
        tick();
        check("mrst_ign_busy", 64'(busy_cnt), 64'(0));
        check("mrst_ign_done", 64'(done_cnt), 64'(0));
        check("mrst_ign_data", 64'(bus.o_data), 64'(0));

        for (int k = 0; k < 16; k++) begin
            d = {$urandom, $urandom};
            c = crc_model(d);
            if ($urandom_range(0, 2) == 0) c = c ^ 8'($urandom_range(1, 255));
            run_frame("rand", d, c, int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
